// File: rtl/serial_adder_if.sv
// Start/done handshake bundle between a controller and the bit-serial adder.
// The controller drives the request side; the adder returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a registered carry, LSB-first
// operand shifters and a sum shifter that is published as a parallel result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sha_q, shb_q, shs_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, busy_q, done_q;

  logic             fa_s, fa_c, last_bit;
  logic [WIDTH-1:0] shs_d;

  // Full-adder cell on the current LSBs and the fed-back carry.
  assign fa_s     = sha_q[0] ^ shb_q[0] ^ carry_q;
  assign fa_c     = (sha_q[0] & shb_q[0]) | (carry_q & (sha_q[0] ^ shb_q[0]));
  assign last_bit = (cnt_q == LAST_BIT);
  assign shs_d    = {fa_s, shs_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      shs_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sha_q   <= bus.a;
            shb_q   <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            shs_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          sha_q   <= sha_q >> 1;
          shb_q   <= shb_q >> 1;
          shs_q   <= shs_d;
          carry_q <= fa_c;
          if (last_bit) begin
            // carry_q here is the carry into the MSB, fa_c the carry out of it.
            sum_q   <= shs_d;
            cout_q  <= fa_c;
            ovf_q   <= carry_q ^ fa_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 vector table and handshake corners,
// plus an exhaustive back-to-back sweep of a WIDTH=3 instance.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(3)) if3 ();

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vt[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One WIDTH=8 operation from IDLE; operands are scrambled right after acceptance.
  task automatic run_op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] s, input logic co, input logic ov);
    logic [7:0] prev;
    int n;
    prev = if8.sum;
    if8.a = a; if8.b = b; if8.cin = cin; if8.start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        if8.start = 1'b0; if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1;
        chk({nm, "_busy"}, 32'(if8.busy), 1);
      end
      if (n == 4) chk({nm, "_hold"}, 32'(if8.sum), 32'(prev));
    end while (!if8.done && n < 40);
    chk({nm, "_lat"}, n, 9);
    chk({nm, "_busy_at_done"}, 32'(if8.busy), 0);
    chk({nm, "_sum"}, 32'(if8.sum), 32'(s));
    chk({nm, "_cout"}, 32'(if8.cout), 32'(co));
    chk({nm, "_ovf"}, 32'(if8.ovf), 32'(ov));
    tick();
    chk({nm, "_done_drop"}, 32'(if8.done), 0);
    chk({nm, "_sum_held"}, 32'(if8.sum), 32'(s));
  endtask

  int n, nd, nb, acc, dn, cyc, last_done;
  logic pb;
  logic [6:0] cb;
  logic [2:0] ea, eb;
  int tot, sa, sb, ss;

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if3.start = 1'b0; if3.a = '0; if3.b = '0; if3.cin = 1'b0;

    repeat (2) tick();
    chk("rst_busy", 32'(if8.busy), 0);
    chk("rst_done", 32'(if8.done), 0);
    chk("rst_sum", 32'(if8.sum), 0);
    chk("rst_cout", 32'(if8.cout), 0);
    chk("rst_ovf", 32'(if8.ovf), 0);
    chk("rst3_sum", 32'(if3.sum), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_busy", 32'(if8.busy), 0);

    vt[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    vt[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vt[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
    vt[9] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++)
      run_op8($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co, vt[i].ov);

    // start while busy, then held start re-accepted in the IDLE cycle after DONE
    if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    n = 1;
    if8.start = 1'b0;
    tick(); tick();
    n = 3;
    if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'hAA;
    do begin tick(); n++; end while (!if8.done && n < 40);
    chk("busy_start_lat", n, 9);
    chk("busy_start_sum", 32'(if8.sum), 32'h02);
    chk("busy_start_cout", 32'(if8.cout), 0);
    tick();
    chk("reaccept_idle_busy", 32'(if8.busy), 0);
    chk("reaccept_idle_done", 32'(if8.done), 0);
    tick();
    chk("reaccept_busy", 32'(if8.busy), 1);
    if8.start = 1'b0;
    n = 1;
    do begin tick(); n++; end while (!if8.done && n < 40);
    chk("reaccept_lat", n, 9);
    chk("reaccept_sum", 32'(if8.sum), 32'h54);
    chk("reaccept_cout", 32'(if8.cout), 1);
    chk("reaccept_ovf", 32'(if8.ovf), 1);
    tick();

    // reset in the middle of ADD
    if8.a = 8'h7F; if8.b = 8'h01; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    repeat (4) tick();
    chk("midrst_pre_busy", 32'(if8.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(if8.busy), 0);
    chk("midrst_done", 32'(if8.done), 0);
    chk("midrst_sum", 32'(if8.sum), 0);
    chk("midrst_cout", 32'(if8.cout), 0);
    chk("midrst_ovf", 32'(if8.ovf), 0);
    tick(); tick();
    rst_n = 1'b1;
    nd = 0; nb = 0;
    repeat (15) begin
      tick();
      if (if8.done) nd++;
      if (if8.busy) nb++;
    end
    chk("midrst_no_done", nd, 0);
    chk("midrst_no_busy", nb, 0);
    run_op8("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // WIDTH=3 exhaustive, start held high, next operands presented after each accept
    {if3.a, if3.b, if3.cin} = 7'd0;
    if3.start = 1'b1;
    acc = 0; dn = 0; cyc = 0; last_done = -1; pb = 1'b0;
    while (dn < 128 && cyc < 1000) begin
      tick();
      cyc++;
      if (if3.busy && !pb) begin
        acc++;
        if (acc < 128) {if3.a, if3.b, if3.cin} = 7'(acc);
        else if3.start = 1'b0;
      end
      chk("w3_excl", 32'(if3.busy & if3.done), 0);
      if (if3.done) begin
        cb = 7'(dn);
        ea = cb[6:4]; eb = cb[3:1];
        tot = int'(ea) + int'(eb) + int'(cb[0]);
        sa = ea[2] ? int'(ea) - 8 : int'(ea);
        sb = eb[2] ? int'(eb) - 8 : int'(eb);
        ss = sa + sb + int'(cb[0]);
        chk($sformatf("w3_sum_%0d", dn), 32'(if3.sum), 32'(tot % 8));
        chk($sformatf("w3_cout_%0d", dn), 32'(if3.cout), 32'(tot / 8));
        chk($sformatf("w3_ovf_%0d", dn), 32'(if3.ovf), ((ss > 3) || (ss < -4)) ? 32'd1 : 32'd0);
        if (last_done >= 0) chk($sformatf("w3_gap_%0d", dn), cyc - last_done, 5);
        last_done = cyc;
        dn++;
      end
      pb = if3.busy;
    end
    chk("w3_count", dn, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
